// File: rtl/video_timing_gen.sv
// Dot/line timing, LCD mode sequencing, STAT/LYC registers and interrupts.
// Build option VIDEO_LINE153_QUIRK_EN: line V_TOTAL-1 reports ly=0 from dot 4.

module video_timing_gen #(
    parameter int H_TOTAL  = 456,
    parameter int V_TOTAL  = 154,
    parameter int V_ACTIVE = 144,
    parameter int OAM_LEN  = 80,
    parameter int XFER_MIN = 172,
    parameter int XFER_MAX = 289,
    parameter int LX_W     = 9,
    parameter int LY_W     = 8
) (
    input  logic            clk2,
    input  logic            nreset_video,
    input  logic            lcd_en,
    input  logic            xfer_done,
    input  logic            reg_wr,
    input  logic            reg_rd,
    input  logic            reg_sel,
    input  logic [7:0]      wdata,
    output logic [7:0]      rdata,
    output logic [LX_W-1:0] lx,
    output logic [LY_W-1:0] ly,
    output logic [1:0]      mode,
    output logic            lyc_match,
    output logic            int_vbl,
    output logic            int_stat
);

    typedef enum logic [1:0] {
        M_HBL  = 2'd0,
        M_VBL  = 2'd1,
        M_OAM  = 2'd2,
        M_XFER = 2'd3
    } mode_t;

    localparam logic [LX_W-1:0] LX_LAST = LX_W'(H_TOTAL - 1);
    localparam logic [LX_W-1:0] LX_OAM  = LX_W'(OAM_LEN);
    localparam logic [LX_W-1:0] LX_XLO  = LX_W'(OAM_LEN + XFER_MIN - 1);
    localparam logic [LX_W-1:0] LX_XHI  = LX_W'(OAM_LEN + XFER_MAX - 1);
    localparam logic [LY_W-1:0] LY_LAST = LY_W'(V_TOTAL - 1);
    localparam logic [LY_W-1:0] LY_VBL  = LY_W'(V_ACTIVE);

    mode_t           mode_q;
    mode_t           mode_n;
    logic [LX_W-1:0] lx_q;
    logic [LX_W-1:0] lx_n;
    logic [LY_W-1:0] ly_q;
    logic [LY_W-1:0] ly_n;
    logic [LY_W-1:0] ly_eff_n;
    logic [7:0]      lyc_q;
    logic [7:0]      lyc_n;
    logic [3:0]      en_q;
    logic [3:0]      en_n;
    logic            match_q;
    logic            match_n;
    logic            stat_q;
    logic            stat_n;
    logic            run_q;
    logic            vbl_q;
    logic            vbl_n;
    logic            istat_q;
    logic            xfer_end;

    always_comb begin
        lyc_n = lyc_q;
        en_n  = en_q;
        if (reg_wr && reg_sel)
            lyc_n = wdata;
        if (reg_wr && !reg_sel)
            en_n = wdata[6:3];

        xfer_end = (mode_q == M_XFER) &&
                   ((xfer_done && lx_q >= LX_XLO) ||
                    lx_q == LX_XHI);

        // First enabled edge parks at dot 0 rather than counting past it
        lx_n  = '0;
        ly_n  = '0;
        vbl_n = 1'b0;
        if (run_q) begin
            if (lx_q == LX_LAST) begin
                ly_n  = (ly_q == LY_LAST) ? '0 : ly_q + 1'b1;
                vbl_n = (ly_n == LY_VBL);
            end else begin
                lx_n = lx_q + 1'b1;
                ly_n = ly_q;
            end
        end

        if (ly_n >= LY_VBL)
            mode_n = M_VBL;
        else if (lx_n < LX_OAM)
            mode_n = M_OAM;
        else if (lx_n == LX_OAM)
            mode_n = M_XFER;
        else if (mode_q == M_XFER && !xfer_end)
            mode_n = M_XFER;
        else
            mode_n = M_HBL;
    end

`ifdef VIDEO_LINE153_QUIRK_EN
    localparam logic [LX_W-1:0] LX_QRK = LX_W'(4);

    assign ly_eff_n = (ly_n == LY_LAST && lx_n >= LX_QRK) ? '0 : ly_n;
    assign ly       = (ly_q == LY_LAST && lx_q >= LX_QRK) ? '0 : ly_q;
`else
    assign ly_eff_n = ly_n;
    assign ly       = ly_q;
`endif

    assign match_n = (32'(ly_eff_n) == 32'(lyc_n));

    assign stat_n = (en_n[3] & match_n) |
                    (en_n[2] & (mode_n == M_OAM)) |
                    (en_n[1] & (mode_n == M_VBL)) |
                    (en_n[0] & (mode_n == M_HBL));

    always_ff @(posedge clk2) begin
        if (!nreset_video) begin
            lx_q    <= '0;
            ly_q    <= '0;
            mode_q  <= M_HBL;
            lyc_q   <= '0;
            en_q    <= '0;
            match_q <= 1'b0;
            stat_q  <= 1'b0;
            run_q   <= 1'b0;
            vbl_q   <= 1'b0;
            istat_q <= 1'b0;
        end else begin
            lyc_q <= lyc_n;
            en_q  <= en_n;
            if (!lcd_en) begin
                lx_q    <= '0;
                ly_q    <= '0;
                mode_q  <= M_HBL;
                match_q <= 1'b0;
                stat_q  <= 1'b0;
                run_q   <= 1'b0;
                vbl_q   <= 1'b0;
                istat_q <= 1'b0;
            end else begin
                lx_q    <= lx_n;
                ly_q    <= ly_n;
                mode_q  <= mode_n;
                match_q <= match_n;
                stat_q  <= stat_n;
                run_q   <= 1'b1;
                vbl_q   <= vbl_n;
                istat_q <= stat_n & ~stat_q;
            end
        end
    end

    assign lx        = lx_q;
    assign mode      = mode_q;
    assign lyc_match = match_q;
    assign int_vbl   = vbl_q;
    assign int_stat  = istat_q;

    assign rdata = !reg_rd ? 8'h00 :
                   reg_sel ? lyc_q :
                   {1'b1, en_q, match_q, mode_q};

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: frame-position reference model plus directed
// checkpoints for line timing, mode 3 end, LYC/STAT interrupts and vblank.

module tb_video_timing_gen;

    localparam int H    = 456;
    localparam int V    = 154;
    localparam int VA   = 144;
    localparam int OAM  = 80;
    localparam int XMIN = 172;
    localparam int XMAX = 289;

    logic       clk2 = 1'b0;
    logic       nreset_video;
    logic       lcd_en;
    logic       xfer_done;
    logic       reg_wr;
    logic       reg_rd;
    logic       reg_sel;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic [8:0] lx;
    logic [7:0] ly;
    logic [1:0] mode;
    logic       lyc_match;
    logic       int_vbl;
    logic       int_stat;

    always #5 clk2 = ~clk2;

    video_timing_gen dut (
        .clk2        (clk2),
        .nreset_video(nreset_video),
        .lcd_en      (lcd_en),
        .xfer_done   (xfer_done),
        .reg_wr      (reg_wr),
        .reg_rd      (reg_rd),
        .reg_sel     (reg_sel),
        .wdata       (wdata),
        .rdata       (rdata),
        .lx          (lx),
        .ly          (ly),
        .mode        (mode),
        .lyc_match   (lyc_match),
        .int_vbl     (int_vbl),
        .int_stat    (int_stat)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: absolute dot position within the frame.
    int         m_pos  = 0;
    bit         m_run  = 0;
    int         m_hb   = H;
    logic [7:0] m_lyc  = 0;
    logic [3:0] m_en   = 0;
    bit         m_prev = 0;
    int         e_lx   = 0;
    int         e_ly   = 0;
    int         e_mode = 0;
    bit         e_match = 0;
    bit         e_vbl  = 0;
    bit         e_stat = 0;
    logic [7:0] e_rd;

    int n_stat = 0;
    int n_vbl  = 0;
    int mc[4];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int  plx;
        int  line;
        bit  was3;
        bit  st;
        plx  = m_pos % H;
        was3 = (e_mode == 3);
        if (!nreset_video) begin
            m_pos = 0; m_run = 0; m_lyc = 0; m_en = 0; m_prev = 0;
            e_lx = 0; e_ly = 0; e_mode = 0;
            e_match = 0; e_vbl = 0; e_stat = 0;
            return;
        end
        if (reg_wr) begin
            if (reg_sel) m_lyc = wdata;
            else         m_en  = wdata[6:3];
        end
        if (!lcd_en) begin
            m_pos = 0; m_run = 0; m_prev = 0;
            e_lx = 0; e_ly = 0; e_mode = 0;
            e_match = 0; e_vbl = 0; e_stat = 0;
            return;
        end
        e_vbl = 0;
        if (!m_run) begin
            m_run = 1;
            m_pos = 0;
            m_hb  = H;
        end else begin
            if (was3 && ((xfer_done && plx >= OAM + XMIN - 1) ||
                         plx == OAM + XMAX - 1))
                m_hb = plx + 1;
            m_pos = (m_pos + 1) % (H * V);
            if (m_pos % H == 0) begin
                m_hb  = H;
                e_vbl = (m_pos / H == VA);
            end
        end
        e_lx = m_pos % H;
        line = m_pos / H;
        e_ly = line;
`ifdef VIDEO_LINE153_QUIRK_EN
        if (line == V - 1 && e_lx >= 4) e_ly = 0;
`endif
        if (line >= VA)      e_mode = 1;
        else if (e_lx < OAM) e_mode = 2;
        else if (e_lx < m_hb) e_mode = 3;
        else                 e_mode = 0;
        e_match = (e_ly == int'(m_lyc));
        st = (m_en[3] && e_match) || (m_en[2] && e_mode == 2) ||
             (m_en[1] && e_mode == 1) || (m_en[0] && e_mode == 0);
        e_stat = st && !m_prev;
        m_prev = st;
    endtask

    task automatic tick();
        @(posedge clk2);
        #1;
        model_step();
        if (!reg_rd)      e_rd = 8'h00;
        else if (reg_sel) e_rd = m_lyc;
        else              e_rd = {1'b1, m_en, e_match, 2'(e_mode)};
        chk("lx",        32'(lx),        e_lx);
        chk("ly",        32'(ly),        e_ly);
        chk("mode",      32'(mode),      e_mode);
        chk("lyc_match", 32'(lyc_match), 32'(e_match));
        chk("int_vbl",   32'(int_vbl),   32'(e_vbl));
        chk("int_stat",  32'(int_stat),  32'(e_stat));
        chk("rdata",     32'(rdata),     32'(e_rd));
        if (int_stat === 1'b1) n_stat++;
        if (int_vbl === 1'b1)  n_vbl++;
    endtask

    task automatic wr(input bit sel, input logic [7:0] d);
        reg_wr  = 1'b1;
        reg_sel = sel;
        wdata   = d;
        tick();
        reg_wr  = 1'b0;
    endtask

    task automatic run_to(input int line, input int dot, input bit rnd);
        int tgt;
        int n;
        tgt = line * H + dot;
        n   = 0;
        while (m_pos != tgt && n < 2 * H * V) begin
            if (rnd) begin
                xfer_done = ($urandom_range(0, 7) == 0);
                reg_rd    = 1'($urandom_range(0, 1));
                reg_sel   = 1'($urandom_range(0, 1));
                reg_wr    = ($urandom_range(0, 63) == 0);
                wdata     = 8'($urandom);
            end
            tick();
            n++;
        end
        xfer_done = 1'b0;
        reg_wr    = 1'b0;
        reg_rd    = 1'b0;
        if (m_pos != tgt) chk("run_to_bound", m_pos, tgt);
    endtask

    initial begin
        nreset_video = 1'b0;
        lcd_en       = 1'b0;
        xfer_done    = 1'b0;
        reg_wr       = 1'b0;
        reg_rd       = 1'b0;
        reg_sel      = 1'b0;
        wdata        = 8'h00;
        for (int i = 0; i < 4; i++) mc[i] = 0;

        tick();
        tick();
        chk("rst_lx",   32'(lx),       0);
        chk("rst_mode", 32'(mode),     0);
        chk("rst_int",  32'({int_vbl, int_stat}), 0);

        // One full line with no xfer_done
        nreset_video = 1'b1;
        lcd_en       = 1'b1;
        for (int i = 0; i < H; i++) begin
            tick();
            mc[mode]++;
        end
        chk("line0_oam",  mc[2], 80);
        chk("line0_xfer", mc[3], 289);
        chk("line0_hbl",  mc[0], 87);
        tick();
        chk("line1_ly", 32'(ly), 1);
        chk("line1_lx", 32'(lx), 0);

        // Early xfer_done ignored, first legal one ends mode 3
        run_to(1, 100, 0);
        xfer_done = 1'b1;
        tick();
        xfer_done = 1'b0;
        chk("xfer_early", 32'(mode), 3);
        run_to(1, 251, 0);
        xfer_done = 1'b1;
        tick();
        xfer_done = 1'b0;
        chk("xfer_end_lx",   32'(lx),   252);
        chk("xfer_end_mode", 32'(mode), 0);

        // LYC interrupt on entering line 5
        wr(1'b1, 8'h05);
        wr(1'b0, 8'h40);
        n_stat = 0;
        run_to(5, 0, 0);
        chk("lyc_irq",   32'(int_stat), 1);
        run_to(5, 10, 0);
        chk("lyc_cnt",   n_stat, 1);
        reg_rd  = 1'b1;
        reg_sel = 1'b0;
        #1;
        chk("stat_rd", 32'(rdata), 32'h0C6);
        reg_rd  = 1'b0;

        // LYC + hblank sources overlap into a single pulse
        run_to(6, 100, 0);
        wr(1'b0, 8'h48);
        n_stat = 0;
        wr(1'b1, 8'h06);
        run_to(6, 369, 0);
        chk("hbl_mode",  32'(mode),     0);
        chk("hbl_nopls", 32'(int_stat), 0);
        run_to(7, 10, 0);
        chk("blk_cnt",   n_stat, 1);
        wr(1'b0, 8'h00);

        // Randomized traffic through the active area
        run_to(143, 0, 1);
        wr(1'b0, 8'h10);
        wr(1'b1, 8'hFF);
        n_vbl = 0;
        run_to(144, 0, 0);
        chk("vbl_pulse", 32'(int_vbl),  1);
        chk("vbl_mode",  32'(mode),     1);
        chk("vbl_stat",  32'(int_stat), 1);
`ifdef VIDEO_LINE153_QUIRK_EN
        run_to(152, 0, 0);
        wr(1'b1, 8'h00);
        wr(1'b0, 8'h40);
        run_to(153, 4, 0);
        chk("q_ly",    32'(ly),        0);
        chk("q_match", 32'(lyc_match), 1);
        chk("q_stat",  32'(int_stat),  1);
`else
        run_to(153, 4, 0);
        chk("l153_ly", 32'(ly), 153);
`endif
        run_to(153, 455, 0);
        chk("wrap_lx", 32'(lx), 455);
        tick();
        chk("wrap_ly",   32'(ly),   0);
        chk("wrap_mode", 32'(mode), 2);
        chk("vbl_cnt",   n_vbl, 1);

        // Mid-line reset beats a same-cycle LYC write
        run_to(0, 200, 0);
        nreset_video = 1'b0;
        reg_wr       = 1'b1;
        reg_sel      = 1'b1;
        wdata        = 8'h33;
        tick();
        reg_wr       = 1'b0;
        nreset_video = 1'b1;
        chk("mrst_lx",   32'(lx),   0);
        chk("mrst_mode", 32'(mode), 0);
        reg_rd  = 1'b1;
        reg_sel = 1'b1;
        #1;
        chk("mrst_lyc", 32'(rdata), 0);
        reg_rd  = 1'b0;
        tick();
        chk("mrst_start", 32'(mode), 2);
        tick();
        chk("mrst_lx1", 32'(lx), 1);

        // Display disable keeps registers live
        run_to(0, 50, 0);
        lcd_en = 1'b0;
        tick();
        chk("off_lx",   32'(lx),   0);
        chk("off_mode", 32'(mode), 0);
        wr(1'b1, 8'h22);
        reg_rd  = 1'b1;
        reg_sel = 1'b1;
        #1;
        chk("off_lyc", 32'(rdata), 32'h22);
        reg_rd  = 1'b0;
        lcd_en  = 1'b1;
        tick();
        chk("on_lx",   32'(lx),   0);
        chk("on_mode", 32'(mode), 2);
        run_to(0, 30, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter H_TOTAL, default 456, dots per line.
REQ-002 SHALL have parameter V_TOTAL, default 154, lines per frame.
REQ-003 SHALL have parameter V_ACTIVE, default 144, first vblank line.
REQ-004 SHALL have parameter OAM_LEN, default 80, mode-2 dots per line.
REQ-005 SHALL have parameter XFER_MIN, default 172, earliest mode-3 end, in dots after OAM_LEN.
REQ-006 SHALL have parameter XFER_MAX, default 289, forced mode-3 length.
REQ-007 SHALL have parameters LX_W, default 9, and LY_W, default 8, counter widths.
REQ-008 SHALL have port clk2, input, 1, dot clock; all state updates on its rising edge.
REQ-009 SHALL have port nreset_video, input, 1: one clock; reset is synchronous and active-low.
REQ-010 SHALL have ports lcd_en (in, 1, display enable) and xfer_done (in, 1, pixel pipe finished line).
REQ-011 SHALL have ports reg_wr, reg_rd (in, 1), reg_sel (in, 1; 0=STAT, 1=LYC), wdata (in, 8) and rdata (out, 8).
REQ-012 SHALL have outputs lx (LX_W), ly (LY_W), mode (2), lyc_match (1), int_vbl (1) and int_stat (1).

Function
REQ-013 While lcd_en=1, lx SHALL increment each cycle; at lx=H_TOTAL-1 it SHALL wrap to 0 and ly SHALL increment; at ly=V_TOTAL-1 ly SHALL wrap to 0.
REQ-014 mode SHALL be registered and track the same edge as lx/ly: ly>=V_ACTIVE -> 1; else lx<OAM_LEN -> 2; else 3 until mode-3 end; then 0 until line end.
REQ-015 Mode 3 SHALL end (mode 0 next cycle) on the first xfer_done=1 with lx>=OAM_LEN+XFER_MIN-1, or at lx=OAM_LEN+XFER_MAX-1; xfer_done SHALL be ignored earlier and outside mode 3.
REQ-016 lyc_match SHALL be registered (ly==lyc), evaluated on post-update ly and lyc, so a same-cycle LYC write and ly change both count.
REQ-017 STAT read SHALL return {1, en[6:3], lyc_match, mode}; LYC read SHALL return lyc; rdata SHALL be 0x00 when reg_rd=0.
REQ-018 STAT writes SHALL update only en[6:3]; wdata[2:0] SHALL be ignored. LYC writes SHALL load all 8 bits.
REQ-019 stat_line = (en6&lyc_match)|(en5&mode==2)|(en4&mode==1)|(en3&mode==0); int_stat SHALL pulse one cycle on each 0->1 transition of stat_line. Overlapping sources SHALL produce one pulse (blocking).
REQ-020 int_vbl SHALL pulse one cycle in the cycle where ly becomes V_ACTIVE and lx becomes 0.
REQ-021 lcd_en=0 SHALL clear lx, ly, mode, lyc_match and stat_line history next cycle and suppress both interrupts; registers SHALL stay accessible. On lcd_en 0->1, counting SHALL start at lx=0, ly=0, mode 2.

Reset
REQ-022 nreset_video=0 at a clk2 edge SHALL clear lx, ly, mode, lyc, en[6:3], lyc_match, stat_line history, int_vbl and int_stat; mid-frame reset SHALL take effect at that edge with no interrupt pulse.
REQ-023 Reset SHALL take priority over lcd_en and register writes in the same cycle.

Configuration
REQ-024 With macro VIDEO_LINE153_QUIRK_EN defined, during ly=V_TOTAL-1 with lx>=4 the ly output and LYC compare SHALL use value 0; the internal line count SHALL be unchanged. Without the macro, ly SHALL always equal the internal count.

Verification
REQ-025 Reset, lcd_en=1, xfer_done=0 -> mode 2 for lx 0..79, 3 for 80..368, 0 for 369..455; ly=1 after 456 cycles.
REQ-026 xfer_done pulsed at lx=100 then at lx=251 -> first ignored; mode=0 from lx=252.
REQ-027 Run to ly=144 -> single int_vbl pulse at lx=0, mode=1; after ly=153 lx=455 -> ly=0, mode=2.
REQ-028 LYC=0x05, STAT write 0x40 -> one int_stat pulse on entering ly=5; STAT read during OAM = 0xC6.
REQ-029 STAT write 0x48, LYC=ly of a line ending in hblank -> exactly one int_stat pulse; no pulse at hblank start.
REQ-030 Macro defined, LYC=0x00 -> ly reads 0 from lx=4 of line 153; lyc_match=1 there, with one int_stat pulse if en6 set.
